// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the single-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam int MAX_D_STREAK_DEF = 4;

    function automatic int streak_width(input int max_streak);
        return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/arb_select.sv
// Combinational owner selection: data has priority unless a fetch has been
// starved for MAX_D_STREAK data grants. A flushed fetch request is not a request.
module arb_select
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEF,
    parameter int SW           = streak_width(MAX_D_STREAK)
) (
    input  logic          if_req,
    input  logic          d_req,
    input  logic [SW-1:0] streak,
    input  logic          if_flush,
    output owner_e        owner,
    output logic          gnt_valid
);

    logic if_eff;
    logic fetch_due;

    always_comb begin
        if_eff    = if_req & ~if_flush;
        fetch_due = if_eff && (streak == SW'(MAX_D_STREAK));
        owner     = OWN_D;
        gnt_valid = 1'b0;
        if (d_req && !fetch_due) begin
            owner     = OWN_D;
            gnt_valid = 1'b1;
        end else if (if_eff) begin
            owner     = OWN_IF;
            gnt_valid = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-port memory, one transaction in flight:
// IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem
);

    localparam int SW = streak_width(MAX_D_STREAK);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          drop_q, drop_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;

    owner_e sel_owner;
    logic   sel_valid;
    logic   if_eff;

    arb_select #(
        .MAX_D_STREAK (MAX_D_STREAK),
        .SW           (SW)
    ) u_arb_select (
        .if_req    (if_req),
        .d_req     (d_req),
        .streak    (streak_q),
        .if_flush  (if_flush),
        .owner     (sel_owner),
        .gnt_valid (sel_valid)
    );

    assign if_eff = if_req & ~if_flush;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        streak_d   = streak_q;
        drop_d     = drop_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            IDLE: begin
                streak_d = '0;
                if (sel_valid) begin
                    owner_d = sel_owner;
                    state_d = ISSUE;
                    if (sel_owner == OWN_IF) begin
                        addr_d  = if_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                        be_d    = 4'b1111;
                    end else begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                        be_d    = d_be;
                        // Streak only counts data grants that a live fetch had to wait behind.
                        if (if_eff) begin
                            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
                        end
                    end
                end
            end
            ISSUE: begin
                if (owner_q == OWN_IF && if_flush) drop_d = 1'b1;
                if (mem_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (owner_q == OWN_IF && if_flush) drop_d = 1'b1;
                if (mem_rvalid) begin
                    if (owner_q == OWN_IF) if_rdata_d = mem_rdata;
                    else                   d_rdata_d  = mem_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                drop_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            streak_q   <= '0;
            drop_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            streak_q   <= streak_d;
            drop_q     <= drop_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // A flush arriving in RESP itself must still suppress the fetch pulse.
    assign if_ready  = (state_q == RESP) && (owner_q == OWN_IF) && !drop_q && !if_flush;
    assign d_ready   = (state_q == RESP) && (owner_q == OWN_D);
    assign mem_req   = (state_q == ISSUE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected completions queued at request time,
// popped on every ready pulse.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        if_req, if_flush, if_ready;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_ready;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        stall_if, stall_mem;

    logic        auto_mem;
    logic        m_gnt, m_rvalid;
    logic [31:0] m_rdata;
    logic        a_rvalid;
    logic [31:0] a_rdata;
    logic        acc_now;
    logic [31:0] acc_addr;

    typedef struct packed {
        logic        is_if;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_chk   = 0;
    int   n_fail  = 0;
    int   n_ready = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_D_STREAK(4)) dut (
        .clk        (clk),
        .clr        (clr),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .if_ready   (if_ready),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_be       (d_be),
        .d_ready    (d_ready),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .stall_if   (stall_if),
        .stall_mem  (stall_mem)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) + 32'h0000_0011;
    endfunction

    // Memory: either bench-driven cycle by cycle, or an auto responder that
    // grants immediately and answers one cycle later.
    assign mem_gnt    = auto_mem ? mem_req  : m_gnt;
    assign mem_rvalid = auto_mem ? a_rvalid : m_rvalid;
    assign mem_rdata  = auto_mem ? a_rdata  : m_rdata;

    always @(negedge clk) begin
        acc_now  = auto_mem && mem_req && mem_gnt;
        acc_addr = mem_addr;
    end

    always @(posedge clk) begin
        #1;
        a_rvalid = acc_now;
        a_rdata  = acc_now ? mem_fn(acc_addr) : 32'h0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (if_ready || d_ready) begin
            n_ready++;
            chk("one_ready", 32'(if_ready & d_ready), 32'h0);
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_ready", 32'h1, 32'h0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_owner", 32'(if_ready), 32'(mon_e.is_if));
                chk("sb_rdata", mon_e.is_if ? if_rdata : d_rdata, mon_e.data);
            end
        end
    end

    task automatic run_txn(input bit is_if, input logic [31:0] addr, input string tag);
        int   lat;
        bit   got;
        exp_t e;
        e.is_if = is_if;
        e.data  = mem_fn(addr);
        sb_q.push_back(e);
        if (is_if) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            d_req  = 1'b1;
            d_we   = 1'b0;
            d_addr = addr;
            d_be   = 4'hF;
        end
        got = 1'b0;
        lat = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (is_if ? if_ready : d_ready) begin
                got = 1'b1;
                lat = c;
                break;
            end
        end
        chk({tag, "_done"}, 32'(got), 32'h1);
        if (got) chk({tag, "_lat"}, 32'(lat), 32'd3);
        step();
        if_req = 1'b0;
        d_req  = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        bit   got;
        int   base;

        if_req = 0; if_addr = 0; if_flush = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        auto_mem = 0; m_gnt = 0; m_rvalid = 0; m_rdata = 0;
        a_rvalid = 0; a_rdata = 0; acc_now = 0; acc_addr = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_be", 32'(mem_be), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_ready", 32'({if_ready, d_ready}), 32'h0);
        step();
        clr = 1'b0;
        step();

        // Lone data read, minimum latency, bench-driven memory.
        d_req = 1; d_we = 0; d_addr = 32'h100; d_be = 4'hF;
        sb_q.push_back('{1'b0, 32'hDEADBEEF});
        @(negedge clk);
        chk("s1_stall_c0", 32'(stall_mem), 32'h1);
        chk("s1_req_c0", 32'(mem_req), 32'h0);
        step(); m_gnt = 1;
        @(negedge clk);
        chk("s1_req_c1", 32'(mem_req), 32'h1);
        chk("s1_addr_c1", mem_addr, 32'h100);
        chk("s1_we_c1", 32'(mem_we), 32'h0);
        chk("s1_stall_c1", 32'(stall_mem), 32'h1);
        step(); m_gnt = 0; m_rvalid = 1; m_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("s1_req_c2", 32'(mem_req), 32'h0);
        chk("s1_stall_c2", 32'(stall_mem), 32'h1);
        chk("s1_ready_c2", 32'(d_ready), 32'h0);
        step(); m_rvalid = 0; m_rdata = 0;
        @(negedge clk);
        chk("s1_ready_c3", 32'(d_ready), 32'h1);
        chk("s1_stall_c3", 32'(stall_mem), 32'h0);
        step(); d_req = 0;
        @(negedge clk);
        chk("s1_ready_c4", 32'(d_ready), 32'h0);
        chk("s1_rdata_hold", d_rdata, 32'hDEADBEEF);
        step();

        // Data write: command fields during ISSUE.
        d_req = 1; d_we = 1; d_addr = 32'h200; d_be = 4'b0011; d_wdata = 32'h1234;
        sb_q.push_back('{1'b0, 32'hCAFE0002});
        @(negedge clk);
        step(); m_gnt = 1;
        @(negedge clk);
        chk("s2_req", 32'(mem_req), 32'h1);
        chk("s2_we", 32'(mem_we), 32'h1);
        chk("s2_be", 32'(mem_be), 32'h3);
        chk("s2_wdata", mem_wdata, 32'h1234);
        chk("s2_addr", mem_addr, 32'h200);
        step(); m_gnt = 0; m_rvalid = 1; m_rdata = 32'hCAFE0002;
        @(negedge clk);
        chk("s2_ready_c2", 32'(d_ready), 32'h0);
        step(); m_rvalid = 0; m_rdata = 0;
        @(negedge clk);
        chk("s2_ready_c3", 32'(d_ready), 32'h1);
        step(); d_req = 0; d_we = 0; d_wdata = 0;
        step();

        // Grant held off 5 cycles; spurious rvalid and a moving d_addr ignored.
        d_req = 1; d_we = 0; d_addr = 32'h300; d_be = 4'hF;
        sb_q.push_back('{1'b0, 32'h5555AAAA});
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            step();
            m_gnt = 0;
            if (k == 2) d_addr = 32'hFFF;
            m_rvalid = (k == 3);
            m_rdata  = (k == 3) ? 32'hBAD0BAD0 : 32'h0;
            @(negedge clk);
            chk("s5_req_held", 32'(mem_req), 32'h1);
            chk("s5_addr_held", mem_addr, 32'h300);
            chk("s5_no_ready", 32'(d_ready), 32'h0);
        end
        step(); m_rvalid = 0; m_rdata = 0; m_gnt = 1;
        @(negedge clk);
        chk("s5_req_gnt", 32'(mem_req), 32'h1);
        chk("s5_spurious_ignored", d_rdata, 32'hCAFE0002);
        step(); m_gnt = 0; m_rvalid = 1; m_rdata = 32'h5555AAAA; d_addr = 32'h300;
        @(negedge clk);
        chk("s5_ready_wait", 32'(d_ready), 32'h0);
        step(); m_rvalid = 0; m_rdata = 0;
        @(negedge clk);
        chk("s5_ready", 32'(d_ready), 32'h1);
        step(); d_req = 0;
        step();

        auto_mem = 1;

        // Flush in the same cycle IDLE would grant a lone fetch: no grant.
        if_req = 1; if_addr = 32'h90; if_flush = 1;
        @(negedge clk);
        step(); if_flush = 0; if_req = 0;
        @(negedge clk);
        chk("flush_idle_no_grant", 32'(mem_req), 32'h0);
        step();

        // Fetch to 0x40 flushed in WAIT, then a clean fetch to 0x80.
        if_req = 1; if_addr = 32'h40;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("s4_fetch_req", 32'(mem_req), 32'h1);
        chk("s4_fetch_we", 32'(mem_we), 32'h0);
        chk("s4_fetch_be", 32'(mem_be), 32'hF);
        chk("s4_fetch_addr", mem_addr, 32'h40);
        step(); if_flush = 1;
        @(negedge clk);
        chk("s4_ready_wait", 32'(if_ready), 32'h0);
        step(); if_flush = 0; if_req = 0;
        @(negedge clk);
        chk("s4_ready_dropped", 32'(if_ready), 32'h0);
        step();
        run_txn(1'b1, 32'h80, "s4_next");

        // Both requesters held: D,D,D,D,IF,D,D,D,D,IF.
        for (int i = 0; i < 10; i++) begin
            e.is_if = (i % 5 == 4);
            e.data  = mem_fn(e.is_if ? 32'h1000 : 32'h2000);
            sb_q.push_back(e);
        end
        base = n_ready;
        if_addr = 32'h1000; d_addr = 32'h2000; d_we = 0; d_be = 4'hF;
        if_req = 1; d_req = 1;
        got = 0;
        for (int c = 0; c < 200; c++) begin
            step();
            if (n_ready >= base + 10) begin
                if_req = 0;
                d_req  = 0;
                got    = 1;
                break;
            end
        end
        if_req = 0; d_req = 0;
        chk("s3_done", 32'(got), 32'h1);
        step();

        // Reset during WAIT: everything clears at once, no ready pulse.
        d_req = 1; d_we = 0; d_addr = 32'h500; d_be = 4'hF;
        @(negedge clk);
        step();
        step();
        clr = 1;
        #1;
        chk("s6_mem_req", 32'(mem_req), 32'h0);
        chk("s6_mem_we", 32'(mem_we), 32'h0);
        chk("s6_mem_addr", mem_addr, 32'h0);
        chk("s6_mem_wdata", mem_wdata, 32'h0);
        chk("s6_mem_be", 32'(mem_be), 32'h0);
        chk("s6_ready", 32'({if_ready, d_ready}), 32'h0);
        chk("s6_if_rdata", if_rdata, 32'h0);
        chk("s6_d_rdata", d_rdata, 32'h0);
        d_req = 0;
        step();
        step();
        clr = 0;
        step();
        run_txn(1'b0, 32'h600, "s6_post");

        chk("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_D_STREAK, default 4, the maximum consecutive data grants while a fetch is pending.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port clr  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports if_req  in  1, if_addr  in  32, if_flush  in  1: fetch request, word address, and redirect that discards an outstanding fetch.
REQ-005 SHALL have ports if_ready  out  1 and if_rdata  out  32: fetch-complete pulse and instruction word.
REQ-006 SHALL have ports d_req  in  1, d_we  in  1, d_addr  in  32, d_wdata  in  32, d_be  in  4: data request, write flag, address, store data, byte enables.
REQ-007 SHALL have ports d_ready  out  1 and d_rdata  out  32: data-complete pulse and load word.
REQ-008 SHALL have ports mem_req  out  1, mem_we  out  1, mem_addr  out  32, mem_wdata  out  32, mem_be  out  4: single-port memory command.
REQ-009 SHALL have ports mem_gnt  in  1, mem_rvalid  in  1, mem_rdata  in  32: command accept, response valid (reads and writes), and read data.
REQ-010 SHALL have ports stall_if  out  1 and stall_mem  out  1 for the hazard unit.

Function
REQ-011 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with at most one memory transaction outstanding.
REQ-012 IDLE: on any pending request, SHALL select an owner, register the command fields, and move to ISSUE; otherwise SHALL stay in IDLE.
REQ-013 Owner selection: data wins over fetch, except that fetch wins when streak == MAX_D_STREAK and if_req=1.
REQ-014 streak SHALL increment on a data grant while if_req=1, clear on a fetch grant or when IDLE sees if_req=0, and saturate at MAX_D_STREAK.
REQ-015 ISSUE: mem_req=1 with command fields held stable; on mem_gnt=1 SHALL move to WAIT; mem_req SHALL be 0 in every other state.
REQ-016 WAIT: on mem_rvalid=1 SHALL register mem_rdata into the owner's rdata register and move to RESP; mem_rvalid in any other state SHALL be ignored.
REQ-017 RESP: the owner's ready SHALL be high for exactly this one cycle, then the FSM SHALL return to IDLE.
REQ-018 Minimum latency: request seen in IDLE at cycle 0, mem_gnt at cycle 1, mem_rvalid at cycle 2, ready at cycle 3.
REQ-019 Fetch writes are impossible: a fetch SHALL drive mem_we=0 and mem_be=4'b1111.
REQ-020 Requesters hold req and their fields stable until ready; the arbiter SHALL use only the values registered in IDLE.
REQ-021 if_flush while the fetch is in ISSUE, WAIT or RESP SHALL set a drop flag; the transaction SHALL complete on the memory side, if_ready SHALL stay 0, and the flag SHALL clear on return to IDLE.
REQ-022 if_flush in the same cycle that IDLE grants a fetch SHALL cancel that grant, and the cycle SHALL be re-arbitrated as if if_req=0.
REQ-023 stall_if = if_req & ~if_ready, and stall_mem = d_req & ~d_ready.
REQ-024 if_rdata and d_rdata SHALL hold their last value until overwritten.

Reset
REQ-025 clr SHALL asynchronously force: state=IDLE, streak=0, drop=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, if_ready=0, d_ready=0, if_rdata=0, d_rdata=0.
REQ-026 clr mid-transaction SHALL abandon the transaction without producing a ready pulse; the memory shares clr.

Structure
REQ-027 Package mem_arb_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT, RESP), the owner enum (OWN_IF, OWN_D), and the MAX_D_STREAK default.
REQ-028 Owner selection SHALL live in one combinational sub-module, arb_select, with inputs if_req, d_req, streak and if_flush, and output owner plus a grant-valid flag.

Verification
REQ-029 Scenario 1: lone d_req read at 0x100, with mem_gnt at cycle 1 and rvalid at cycle 2 carrying 0xDEADBEEF -> d_ready at cycle 3 with d_rdata=0xDEADBEEF; stall_mem=1 during cycles 0-2.
REQ-030 Scenario 2: d_req write 0x200, d_be=0011, d_wdata=0x1234 -> mem_we=1, mem_be=0011, mem_wdata=0x1234 during ISSUE; d_ready one cycle after rvalid.
REQ-031 Scenario 3: if_req and d_req both held continuously with MAX_D_STREAK=4 -> grant order D,D,D,D,IF,D,D,D,D,IF.
REQ-032 Scenario 4: if_flush during WAIT of a fetch to 0x40 -> memory completes, if_ready stays 0, and the next fetch (0x80) returns normally.
REQ-033 Scenario 5: mem_gnt held low for 5 cycles in ISSUE -> mem_req and the fields stay stable, no ready pulse, and a spurious mem_rvalid is ignored.
REQ-034 Scenario 6: clr asserted during WAIT -> all outputs read 0 immediately, state=IDLE, no ready pulse, and a post-reset request completes in 4 cycles.
